// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared opcodes, WB select codes and FSM state encoding for the
//               memory stage of the 16-bit pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Memory operation codes carried from the execute stage
    localparam logic [2:0] MEM_NONE = 3'd0;
    localparam logic [2:0] MEM_LW   = 3'd1;
    localparam logic [2:0] MEM_SW   = 3'd2;
    localparam logic [2:0] MEM_LM   = 3'd3;
    localparam logic [2:0] MEM_SM   = 3'd4;

    // Write-back mux selects that route memory data
    localparam logic [1:0] SEL_MEM   = 2'b00;
    localparam logic [1:0] R7SEL_MEM = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } state_t;

    function automatic logic is_single_op(input logic [2:0] op);
        return (op == MEM_LW) || (op == MEM_SW);
    endfunction

    function automatic logic is_multi_op(input logic [2:0] op);
        return (op == MEM_LM) || (op == MEM_SM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_lowest_set_bit8.sv
`default_nettype none
// ============================================================================
// Module      : lowest_set_bit8
// Description : Combinational priority encoder returning the index of the
//               lowest set bit of an 8-bit mask plus an any-bit-set flag.
// Revision    : 1.0 - initial release
// ============================================================================
module lowest_set_bit8 (
    input  logic [7:0] i_mask,
    output logic [2:0] o_idx,
    output logic       o_any
);

    // Scan from the top down so the lowest set bit is the last one to win
    always_comb begin
        o_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = 3'(i);
            end
        end
    end

    assign o_any = |i_mask;

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Memory stage. Runs LW/SW and LM/SM transfers against a
//               req/ready data memory, stalls upstream while busy and
//               registers all write-back operands for the WB stage.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exValid,
    input  logic [2:0]       exMemOp,
    input  logic [15:0]      exALUOut,
    input  logic [15:0]      exStoreData,
    input  logic [NREGS-1:0] exMask,
    input  logic [IDX_W-1:0] exDestReg,
    input  logic             exRegWrite,
    input  logic             exR7Write,
    input  logic [1:0]       exRegSelect,
    input  logic [1:0]       exR7Select,
    input  logic [15:0]      exImm970,
    input  logic [15:0]      exPCImmInc,
    input  logic [15:0]      exPCInc,
    output logic             stall,
    output logic             memReq,
    output logic             memWe,
    output logic [15:0]      memAddr,
    output logic [15:0]      memWData,
    input  logic [15:0]      memRData,
    input  logic             memReady,
    output logic [IDX_W-1:0] smRegAddr,
    input  logic [15:0]      smRegData,
    output logic             wbValid,
    output logic             wbRegWrite,
    output logic             wbR7Write,
    output logic [IDX_W-1:0] wbRegAddr,
    output logic [1:0]       wbRegSelect,
    output logic [1:0]       wbR7Select,
    output logic [15:0]      wbMemData,
    output logic [15:0]      wbALUOut,
    output logic [15:0]      wbImm970,
    output logic [15:0]      wbPCImmInc,
    output logic [15:0]      wbPCInc
);

    state_t             r_state;
    state_t             w_next;

    logic [2:0]         r_op;
    logic [15:0]        r_addr;       // single-op address, or running LM/SM address
    logic [15:0]        r_aluOut;
    logic [15:0]        r_storeData;
    logic [NREGS-1:0]   r_mask;       // LM/SM registers still to transfer
    logic [IDX_W-1:0]   r_destReg;
    logic               r_regWrite;
    logic               r_r7Write;
    logic [1:0]         r_regSelect;
    logic [1:0]         r_r7Select;
    logic [15:0]        r_imm970;
    logic [15:0]        r_pcImmInc;
    logic [15:0]        r_pcInc;

    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    logic [NREGS-1:0]   w_maskNext;
    logic               w_xfer;
    logic               w_exIsMem;
    logic               w_exPassThru;
    logic               w_idxIsR7;

    lowest_set_bit8 u_lsb (
        .i_mask (r_mask),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_maskNext   = r_mask & ~({{(NREGS-1){1'b0}}, 1'b1} << w_idx);
    assign w_xfer       = memReq & memReady;
    assign w_exIsMem    = is_single_op(exMemOp) | is_multi_op(exMemOp);
    // Non-memory ops and empty-mask LM/SM retire straight from IDLE
    assign w_exPassThru = !is_single_op(exMemOp) && !(is_multi_op(exMemOp) && (|exMask));
    assign w_idxIsR7    = (w_idx == IDX_W'(NREGS - 1));
    assign stall        = (r_state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and memory/register-file request outputs
    always_comb begin
        w_next    = r_state;
        memReq    = 1'b0;
        memWe     = 1'b0;
        memAddr   = 16'd0;
        memWData  = 16'd0;
        smRegAddr = '0;
        case (r_state)
            IDLE: begin
                if (exValid && !w_exPassThru) begin
                    w_next = is_single_op(exMemOp) ? SINGLE : MULTI;
                end
            end
            SINGLE: begin
                memReq   = 1'b1;
                memAddr  = r_addr;
                memWe    = (r_op == MEM_SW);
                memWData = r_storeData;
                if (memReady) begin
                    w_next = IDLE;
                end
            end
            MULTI: begin
                memReq  = w_any;
                memAddr = r_addr;
                memWe   = w_any && (r_op == MEM_SM);
                if (r_op == MEM_SM) begin
                    smRegAddr = w_idx;
                    memWData  = smRegData;
                end
                if (!w_any || (memReady && (w_maskNext == '0))) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Field capture, LM/SM progress and write-back register loading
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op        <= MEM_NONE;
            r_addr      <= 16'd0;
            r_aluOut    <= 16'd0;
            r_storeData <= 16'd0;
            r_mask      <= '0;
            r_destReg   <= '0;
            r_regWrite  <= 1'b0;
            r_r7Write   <= 1'b0;
            r_regSelect <= 2'd0;
            r_r7Select  <= 2'd0;
            r_imm970    <= 16'd0;
            r_pcImmInc  <= 16'd0;
            r_pcInc     <= 16'd0;
            wbValid     <= 1'b0;
            wbRegWrite  <= 1'b0;
            wbR7Write   <= 1'b0;
            wbRegAddr   <= '0;
            wbRegSelect <= 2'd0;
            wbR7Select  <= 2'd0;
            wbMemData   <= 16'd0;
            wbALUOut    <= 16'd0;
            wbImm970    <= 16'd0;
            wbPCImmInc  <= 16'd0;
            wbPCInc     <= 16'd0;
        end else begin
            wbValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (exValid) begin
                        r_op        <= exMemOp;
                        r_addr      <= exALUOut;
                        r_aluOut    <= exALUOut;
                        r_storeData <= exStoreData;
                        r_mask      <= exMask;
                        r_destReg   <= exDestReg;
                        r_regWrite  <= exRegWrite;
                        r_r7Write   <= exR7Write;
                        r_regSelect <= exRegSelect;
                        r_r7Select  <= exR7Select;
                        r_imm970    <= exImm970;
                        r_pcImmInc  <= exPCImmInc;
                        r_pcInc     <= exPCInc;
                        if (w_exPassThru) begin
                            wbValid     <= 1'b1;
                            wbRegWrite  <= w_exIsMem ? 1'b0 : exRegWrite;
                            wbR7Write   <= w_exIsMem ? 1'b0 : exR7Write;
                            wbRegAddr   <= exDestReg;
                            wbRegSelect <= exRegSelect;
                            wbR7Select  <= exR7Select;
                            wbALUOut    <= exALUOut;
                            wbImm970    <= exImm970;
                            wbPCImmInc  <= exPCImmInc;
                            wbPCInc     <= exPCInc;
                        end
                    end
                end
                SINGLE: begin
                    if (memReady) begin
                        wbValid     <= 1'b1;
                        wbRegWrite  <= (r_op == MEM_SW) ? 1'b0 : r_regWrite;
                        wbR7Write   <= (r_op == MEM_SW) ? 1'b0 : r_r7Write;
                        wbRegAddr   <= r_destReg;
                        wbRegSelect <= r_regSelect;
                        wbR7Select  <= r_r7Select;
                        wbALUOut    <= r_aluOut;
                        wbImm970    <= r_imm970;
                        wbPCImmInc  <= r_pcImmInc;
                        wbPCInc     <= r_pcInc;
                        if (r_op == MEM_LW) begin
                            wbMemData <= memRData;
                        end
                    end
                end
                MULTI: begin
                    if (w_xfer) begin
                        r_mask      <= w_maskNext;
                        r_addr      <= r_addr + 16'd1;
                        wbValid     <= 1'b1;
                        wbALUOut    <= r_aluOut;
                        wbImm970    <= r_imm970;
                        wbPCImmInc  <= r_pcImmInc;
                        wbPCInc     <= r_pcInc;
                        wbRegAddr   <= w_idx;
                        if (r_op == MEM_LM) begin
                            wbRegWrite  <= 1'b1;
                            wbRegSelect <= SEL_MEM;
                            wbMemData   <= memRData;
                            wbR7Write   <= w_idxIsR7;
                            wbR7Select  <= w_idxIsR7 ? R7SEL_MEM : r_r7Select;
                        end else begin
                            wbRegWrite  <= 1'b0;
                            wbR7Write   <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the 16-bit pipeline, sitting between the execute-stage pipeline register and the write-back mux stage.
- Performs single loads/stores (LW/SW) and multi-register transfers (LM/SM) against a variable-latency data memory using a req/ready handshake.
- Registers every write-back operand (MemData, ALUOut, Imm970, PCImmInc, PCInc, select codes) for the WB stage.
- Stalls upstream while a memory operation is in flight.

Parameters:
- NREGS, 8, number of architectural registers; also the LM/SM mask width.
- IDX_W, 3, register index width, equal to log2(NREGS).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- exValid  in  1  execute stage presents a valid instruction
- exMemOp  in  3  MEM_NONE/LW/SW/LM/SM
- exALUOut  in  16  ALU result; memory address for all memory ops
- exStoreData  in  16  SW data
- exMask  in  8  LM/SM register mask
- exDestReg  in  3  destination register
- exRegWrite, exR7Write  in  1  write enables
- exRegSelect, exR7Select  in  2  WB mux selects
- exImm970, exPCImmInc, exPCInc  in  16  WB operands
- stall  out  1  upstream must hold its instruction
- memReq  out  1  memory request
- memWe  out  1  write strobe
- memAddr  out  16  memory address
- memWData  out  16  memory write data
- memRData  in  16  memory read data
- memReady  in  1  transfer completes this cycle
- smRegAddr  out  3  register-file read index for SM
- smRegData  in  16  register-file read data for SM (combinational)
- wbValid  out  1  WB fields valid this cycle
- wbRegWrite, wbR7Write  out  1  write enables
- wbRegAddr  out  3  destination register
- wbRegSelect, wbR7Select  out  2  WB mux selects
- wbMemData, wbALUOut, wbImm970, wbPCImmInc, wbPCInc  out  16  WB operands

Behaviour:
- Reset: state IDLE; all outputs 0; all captured fields 0; any in-flight transfer abandoned with no WB output. Reset takes priority over every other event.
- stall = (state != IDLE). Registered-state only, with no combinational path from exValid.
- States:
  - IDLE: accepts an instruction when exValid=1.
    - MEM_NONE: WB registers loaded next edge, giving 1-cycle latency; stays IDLE.
    - LW/SW: fields captured, go to SINGLE.
    - LM/SM: fields captured, mask copied to a working mask, addrCnt = exALUOut, go to MULTI. If exMask = 0, no memory access: emit wbValid with wbRegWrite = 0 and wbR7Write = 0, stay IDLE.
  - SINGLE: memReq = 1, memAddr = captured ALUOut, memWe = (op == SW), memWData = captured storeData.
    - Inputs held stable until the memReady cycle.
    - On memReady, next edge: wbValid = 1, wbMemData = memRData (LW only); SW forces wbRegWrite = 0 and wbR7Write = 0. Return to IDLE.
  - MULTI: idx = lowest set bit of the working mask. memReq = 1, memAddr = addrCnt, memWe = (op == SM), smRegAddr = idx, memWData = smRegData.
    - On memReady: clear bit idx and increment addrCnt by 1 (16-bit wrap, 0xFFFF -> 0x0000).
    - LM: wbValid = 1, wbRegWrite = 1, wbRegAddr = idx, wbRegSelect = 2'b00, wbMemData = memRData. If idx = 7, also wbR7Write = 1 and wbR7Select = 2'b01.
    - SM: wbValid = 1 with write enables 0.
    - Return to IDLE after the edge that clears the last bit.
- wbValid is a one-cycle pulse per completed access or op; otherwise 0, and the other wb fields hold their last values.
- Minimum memory-op latency: accept at T, memReq at T+1, memReady at T+1, wbValid at T+2. Back-to-back accepts are possible once stall drops.
- memReady while memReq = 0 is ignored.
- memReq never drops before memReady.
- smRegAddr = 0 outside MULTI/SM.

Decomposition:
- Shared package: MEM_NONE = 3'd0, MEM_LW = 1, MEM_SW = 2, MEM_LM = 3, MEM_SM = 4; state encoding IDLE/SINGLE/MULTI; WB select codes SEL_MEM = 2'b00, R7SEL_MEM = 2'b01.
- One sub-module: lowest_set_bit8 (8-bit mask in; 3-bit index and any-set flag out; combinational).

Test Plan:
- LW, addr 0x0040, memReady 3 cycles after memReq rises, memRData 0xBEEF -> stall high 4 cycles; memReq held with addr 0x0040; single wbValid, wbMemData 0xBEEF, wbRegAddr = exDestReg.
- SW, addr 0x1234, data 0x5A5A, memReady same cycle -> one memReq with memWe = 1, memWData 0x5A5A; wbValid with wbRegWrite = 0; stall for exactly 1 cycle.
- LM, mask 8'b1000_0101, addr 0xFFFF, zero-wait memory returning 0x11/0x22/0x33 -> addresses 0xFFFF, 0x0000, 0x0001; WB writes r0 = 0x11, r2 = 0x22, r7 = 0x33 with wbR7Write = 1 on the third.
- SM, mask 8'b0000_0110, smRegData = 0xA000 + index -> writes mem[a] = 0xA001, mem[a+1] = 0xA002; smRegAddr sequence 1, 2; no register writes.
- LM with mask 0 -> no memReq, stall never asserts, one wbValid with write enables 0.
- Reset asserted during second LM transfer -> next cycle state IDLE, memReq = 0, wbValid = 0, stall = 0; following MEM_NONE op completes normally in 1 cycle.
